// File: rtl/filtered_line_buffer.sv
// filtered_line_buffer: ping-pong line buffer for filtered projection samples
// Drops pDiscardCount leading samples of each line, stores pLineLength samples
// into one of two banks, and serves the other complete bank for random reads.
// Ports:
//   clk, clear         rising-edge clock, synchronous active-high reset
//   fill_enable/val    upstream sample strobe and data
//   fill_ready         a bank is open for writing
//   fill_overrun       sticky: a sample arrived while fill_ready was low
//   read_ready         current read bank holds a complete line
//   read_swap          consumer releases the current read bank
//   read_addr/val      sample index and its data one cycle later
// Macro FILTERED_LINE_BUFFER_ZERO_PAD_EN: out-of-range reads return 0 instead
// of the last sample of the line.
module filtered_line_buffer #(
   parameter int pDataLength   = 16,
   parameter int pLineLength   = 256,
   parameter int pAddrLength   = 8,
   parameter int pDiscardCount = 4
) (
   input  logic                   clk,
   input  logic                   clear,
   input  logic                   fill_enable,
   input  logic [pDataLength-1:0] fill_val,
   output logic                   fill_ready,
   output logic                   fill_overrun,
   output logic                   read_ready,
   input  logic                   read_swap,
   input  logic [pAddrLength-1:0] read_addr,
   output logic [pDataLength-1:0] read_val
);
   localparam int LW = pLineLength > 1 ? $clog2(pLineLength) : 1;
   localparam int DW = pDiscardCount > 1 ? $clog2(pDiscardCount) : 1;
   localparam logic [LW-1:0] LAST = LW'(pLineLength - 1);
   localparam logic [DW-1:0] LAST_DISC = DW'(pDiscardCount - 1);
`ifdef FILTERED_LINE_BUFFER_ZERO_PAD_EN
   localparam bit ZERO_PAD = 1'b1;
`else
   localparam bit ZERO_PAD = 1'b0;
`endif

   typedef enum logic [1:0] {DISCARD, FILL, WAIT_BANK} state_t;
   // With nothing to discard, every new line starts directly in FILL.
   localparam state_t START = pDiscardCount == 0 ? FILL : DISCARD;

   logic [pDataLength-1:0] mem [2][pLineLength];
   state_t                 state;
   logic [1:0]             full;
   logic                   wptr, rptr;
   logic [LW-1:0]          waddr;
   logic [DW-1:0]          dcnt;
   logic                   accept, swap, in_range;

   assign fill_ready = state != WAIT_BANK;
   assign read_ready = full[rptr];
   assign accept     = fill_enable && fill_ready;
   assign swap       = read_swap && read_ready;
   assign in_range   = {1'b0, read_addr} < (pAddrLength + 1)'(pLineLength);

   always_ff @(posedge clk) begin
      if (!clear && state == FILL && accept) mem[wptr][waddr] <= fill_val;
      read_val <= (clear || !read_ready) ? '0 :
                  in_range ? mem[rptr][read_addr[LW-1:0]] :
                  ZERO_PAD ? '0 : mem[rptr][LAST];
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state        <= START;
         full         <= '0;
         wptr         <= 1'b0;
         rptr         <= 1'b0;
         waddr        <= '0;
         dcnt         <= '0;
         fill_overrun <= 1'b0;
      end else begin
         if (fill_enable && !fill_ready) fill_overrun <= 1'b1;
         case (state)
            DISCARD: if (accept) begin
               dcnt <= dcnt == LAST_DISC ? '0 : dcnt + 1'b1;
               if (dcnt == LAST_DISC) state <= FILL;
            end
            FILL: if (accept) begin
               waddr <= waddr == LAST ? '0 : waddr + 1'b1;
               if (waddr == LAST) begin
                  full[wptr] <= 1'b1;
                  // The other bank counts as free if the reader releases it on this edge.
                  if (!full[~wptr] || swap) begin
                     wptr  <= ~wptr;
                     state <= START;
                  end else state <= WAIT_BANK;
               end
            end
            WAIT_BANK: if (!full[~wptr]) begin
               wptr  <= ~wptr;
               state <= START;
            end
            default: state <= START;
         endcase
         // The read bank is always full here, so it never collides with the write bank update.
         if (swap) begin
            full[rptr] <= 1'b0;
            rptr       <= ~rptr;
         end
      end
   end
endmodule

// File: tb/tb_filtered_line_buffer.sv
// tb_filtered_line_buffer: directed and random checks of filtered_line_buffer against a queue-free line model
module tb_filtered_line_buffer;
   localparam int L = 8;
   localparam int D = 3;
`ifdef FILTERED_LINE_BUFFER_ZERO_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        clear = 1'b1, fill_enable = 1'b0, read_swap = 1'b0;
   logic [15:0] fill_val = '0;
   logic [3:0]  read_addr = '0;
   logic        fill_ready, fill_overrun, read_ready;
   logic [15:0] read_val;

   filtered_line_buffer #(.pDataLength(16), .pLineLength(L), .pAddrLength(4), .pDiscardCount(D)) dut (
      .clk(clk), .clear(clear), .fill_enable(fill_enable), .fill_val(fill_val),
      .fill_ready(fill_ready), .fill_overrun(fill_overrun), .read_ready(read_ready),
      .read_swap(read_swap), .read_addr(read_addr), .read_val(read_val)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   bit checking = 1'b0;

   // Model: each bank is a line of samples plus a "complete" flag; the writer
   // is described by how many samples it still has to throw away, how many it
   // has stored, and whether it is stalled waiting for the reader.
   int       bank [2][L];
   bit       m_full [2];
   int       m_wb, m_rb, m_disc_left, m_stored;
   bit       m_wait, m_ovr;
   logic [15:0] m_rv;

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (clear) begin
         m_full = '{0, 0};
         m_wb = 0; m_rb = 0; m_disc_left = D; m_stored = 0;
         m_wait = 0; m_ovr = 0; m_rv = '0;
      end else begin
         bit rdy, freed;
         rdy = m_full[m_rb];
         m_rv = !rdy ? 16'd0 : read_addr < L ? 16'(bank[m_rb][read_addr]) : PAD ? 16'd0 : 16'(bank[m_rb][L-1]);
         freed = read_swap && rdy;
         if (fill_enable && m_wait) m_ovr = 1;
         if (m_wait) begin
            if (!m_full[1-m_wb]) begin
               m_wb = 1 - m_wb; m_wait = 0; m_disc_left = D; m_stored = 0;
            end
         end else if (fill_enable) begin
            if (m_disc_left > 0) m_disc_left--;
            else begin
               bank[m_wb][m_stored] = fill_val;
               m_stored++;
               if (m_stored == L) begin
                  m_full[m_wb] = 1;
                  if (!m_full[1-m_wb] || freed) begin
                     m_wb = 1 - m_wb; m_disc_left = D; m_stored = 0;
                  end else m_wait = 1;
               end
            end
         end
         if (freed) begin
            m_full[m_rb] = 0; m_rb = 1 - m_rb;
         end
      end
   end

   always @(negedge clk) if (checking) begin
      chk("fill_ready", fill_ready, !m_wait);
      chk("read_ready", read_ready, m_full[m_rb]);
      chk("fill_overrun", fill_overrun, m_ovr);
      chk("read_val", read_val, m_rv);
   end

   task automatic cyc(input logic c, input logic fe, input logic [15:0] v, input logic rs, input logic [3:0] a);
      clear = c; fill_enable = fe; fill_val = v; read_swap = rs; read_addr = a;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      cyc(1, 0, 0, 0, 0);
      checking = 1'b1;
      cyc(1, 1, 7, 1, 0);
      chk("reset fill_ready", fill_ready, 1);
      chk("reset read_ready", read_ready, 0);
      chk("reset overrun", fill_overrun, 0);
      chk("reset read_val", read_val, 0);
      // first line: 1..3 discarded, 4..11 stored
      for (int v = 1; v <= 11; v++) begin
         cyc(0, 1, 16'(v), 0, 0);
         if (v == 10) chk("not ready before last", read_ready, 0);
      end
      chk("line0 ready", read_ready, 1);
      chk("line0 fill_ready", fill_ready, 1);
      for (int v = 12; v <= 22; v++) cyc(0, 1, 16'(v), 0, 0);
      chk("both full stall", fill_ready, 0);
      chk("no overrun yet", fill_overrun, 0);
      cyc(0, 1, 99, 0, 0);
      chk("overrun set", fill_overrun, 1);
      cyc(0, 0, 0, 0, 0);
      chk("read b0[0]", read_val, 4);
      cyc(0, 0, 0, 0, 7);
      chk("read b0[7]", read_val, 11);
      cyc(0, 0, 0, 0, 9);
      chk("read out of range", read_val, PAD ? 0 : 11);
      cyc(0, 0, 0, 1, 0);
      chk("read during swap", read_val, 4);
      cyc(0, 0, 0, 0, 0);
      chk("read b1[0]", read_val, 15);
      chk("resume after swap", fill_ready, 1);
      cyc(0, 0, 0, 0, 7);
      chk("read b1[7]", read_val, 22);
      // last sample of a line lands on the same edge the reader frees the other bank
      for (int i = 0; i <= 10; i++) cyc(0, 1, 16'(100 + i), i == 10, 0);
      chk("no stall on swap edge", fill_ready, 1);
      chk("new line readable", read_ready, 1);
      cyc(0, 0, 0, 0, 3);
      chk("read new b0[3]", read_val, 106);
      // clear mid-line
      for (int i = 0; i < 8; i++) cyc(0, 1, 16'(200 + i), 0, 0);
      chk("overrun still sticky", fill_overrun, 1);
      cyc(1, 1, 300, 1, 0);
      chk("clear fill_ready", fill_ready, 1);
      chk("clear read_ready", read_ready, 0);
      chk("clear overrun", fill_overrun, 0);
      for (int v = 50; v <= 60; v++) cyc(0, 1, 16'(v), 0, 0);
      chk("post-clear ready", read_ready, 1);
      cyc(0, 0, 0, 0, 0);
      chk("post-clear discard", read_val, 53);
      // random traffic
      for (int i = 0; i < 4000; i++)
         cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, 16'($urandom),
             $urandom_range(0, 3) == 0, 4'($urandom_range(0, 9)));
      checking = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
